// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: turns compare-stage flags into a registered branch
// decision (taken + redirect target) or an SLT/SLTU result word, behind a
// valid/ready handshake, and sequences a flush window after a taken redirect.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [PC_W-1:0] in_pc,
    input  logic [15:0]     in_offset,
    input  logic            cmp_bigger,
    input  logic            cmp_equal,
    input  logic            cmp_less,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [PC_W-1:0] out_target,
    output logic            out_is_slt,
    output logic [31:0]     out_slt,
    output logic            out_err,
    output logic            flush
);

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLEZ = 3'd2,
        OP_BGTZ = 3'd3,
        OP_BLTZ = 3'd4,
        OP_BGEZ = 3'd5,
        OP_SLT  = 3'd6,
        OP_SLTU = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_e;

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_e           state;
    logic [CNT_W-1:0] cnt;

    op_e              op;
    logic             one_hot;
    logic             cond;
    logic             dec_taken;
    logic             dec_is_slt;
    logic             dec_err;
    logic [31:0]      dec_slt;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  dec_target;
    logic             accept;
    logic             hs_taken;

    // Sign-extended word offset; the size cast of a signed operand extends the sign bit.
    assign off_ext = PC_W'($signed(in_offset));

    // Gated by rst_n so the port reads 0 while reset is held.
    assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign hs_taken = out_valid && out_ready && out_taken;

    // Decode the op against the compare flags into the decision to be registered.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        cond       = 1'b0;
        op         = op_e'(in_op);
        one_hot    = $onehot({cmp_bigger, cmp_equal, cmp_less});
        case (op)
            OP_BEQ:  cond = cmp_equal;
            OP_BNE:  cond = !cmp_equal;
            OP_BLEZ: cond = cmp_less | cmp_equal;
            OP_BGTZ: cond = cmp_bigger;
            OP_BLTZ: cond = cmp_less;
            OP_BGEZ: cond = cmp_bigger | cmp_equal;
            default: cond = 1'b0;
        endcase
        dec_is_slt = (op == OP_SLT) || (op == OP_SLTU);
        dec_err    = !one_hot;
        dec_taken  = one_hot && !dec_is_slt && cond;
        dec_slt    = {31'b0, one_hot && dec_is_slt && cmp_less};
        dec_target = dec_taken ? (in_pc + PC_W'(4) + (off_ext << 2)) : '0;
    end

    // Output decision register: load on accept, drop valid when consumed, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            out_valid  <= 1'b0;
            out_taken  <= 1'b0;
            out_target <= '0;
            out_is_slt <= 1'b0;
            out_slt    <= '0;
            out_err    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_taken  <= dec_taken;
            out_target <= dec_target;
            out_is_slt <= dec_is_slt;
            out_slt    <= dec_slt;
            out_err    <= dec_err;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Flush FSM: a consumed taken redirect opens a FLUSH_CYCLES-long window with flush registered high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            flush <= 1'b0;
        end else if (hs_taken && (FLUSH_CYCLES > 0)) begin
            state <= ST_FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES);
            flush <= 1'b1;
        end else if (state == ST_FLUSH) begin
            if (cnt == CNT_W'(1)) begin
                state <= ST_IDLE;
                cnt   <= '0;
                flush <= 1'b0;
            end else begin
                cnt   <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural reference model
// that derives decisions from the operand values the flags describe.
module tb_branch_resolve_unit;

    localparam int FC   = 2;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic [15:0]     in_offset = '0;
    logic            cmp_bigger = 1'b0;
    logic            cmp_equal = 1'b0;
    logic            cmp_less = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_taken;
    logic [PC_W-1:0] out_target;
    logic            out_is_slt;
    logic [31:0]     out_slt;
    logic            out_err;
    logic            flush;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit        m_valid;
    bit        m_taken;
    bit [31:0] m_target;
    bit        m_is_slt;
    bit [31:0] m_slt;
    bit        m_err;
    int        m_left;

    bit [2:0] bad_tab [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    branch_resolve_unit #(.FLUSH_CYCLES(FC), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_pc      (in_pc),
        .in_offset  (in_offset),
        .cmp_bigger (cmp_bigger),
        .cmp_equal  (cmp_equal),
        .cmp_less   (cmp_less),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_taken  (out_taken),
        .out_target (out_target),
        .out_is_slt (out_is_slt),
        .out_slt    (out_slt),
        .out_err    (out_err),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_taken  = 0;
        m_target = 0;
        m_is_slt = 0;
        m_slt    = 0;
        m_err    = 0;
        m_left   = 0;
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".out_valid"}, out_valid, m_valid);
        check({ctx, ".flush"}, flush, m_left > 0);
        if (m_valid) begin
            check({ctx, ".out_taken"}, out_taken, m_taken);
            check({ctx, ".out_target"}, out_target, m_target);
            check({ctx, ".out_is_slt"}, out_is_slt, m_is_slt);
            check({ctx, ".out_slt"}, out_slt, m_slt);
            check({ctx, ".out_err"}, out_err, m_err);
        end
    endtask

    // One clock cycle: called at a falling edge, drives inputs, checks in_ready,
    // advances the model, then checks registered outputs at the next falling edge.
    task automatic step(input bit v, input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                        input bit bad, input bit [2:0] bad_fl, input bit [31:0] pc,
                        input bit [15:0] off, input bit ordy);
        int     sa, sb;
        bit     gt, eq, lt, tk, rdy;
        bit [2:0] fl;
        longint t;
        if (op inside {[3'd2:3'd5]}) b = 0;
        sa = $signed(a);
        sb = $signed(b);
        gt = (op == 3'd7) ? (a > b) : (sa > sb);
        eq = (a == b);
        lt = (op == 3'd7) ? (a < b) : (sa < sb);
        fl = bad ? bad_fl : {gt, eq, lt};
        in_valid   = v;
        in_op      = op;
        in_pc      = pc;
        in_offset  = off;
        {cmp_bigger, cmp_equal, cmp_less} = fl;
        out_ready  = ordy;
        #1;
        rdy = rst_n && (m_left == 0) && (!m_valid || ordy);
        check("in_ready", in_ready, rdy);
        if (m_valid && ordy && m_taken && FC > 0) m_left = FC;
        else if (m_left > 0) m_left--;
        if (v && rdy) begin
            case (op)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd2: tk = (sa <= 0);
                3'd3: tk = (sa > 0);
                3'd4: tk = (sa < 0);
                3'd5: tk = (sa >= 0);
                default: tk = 0;
            endcase
            m_valid  = 1;
            m_err    = bad;
            m_is_slt = (op >= 3'd6);
            m_taken  = tk && !bad;
            if (op == 3'd6)      m_slt = (!bad && sa < sb) ? 32'd1 : 32'd0;
            else if (op == 3'd7) m_slt = (!bad && a < b) ? 32'd1 : 32'd0;
            else                 m_slt = 32'd0;
            t = longint'(pc) + 4 + longint'($signed(off)) * 4;
            m_target = m_taken ? t[31:0] : 32'd0;
        end else if (ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
        check_outputs("step");
    endtask

    initial begin
        bit [31:0] ra, rb;
        model_reset();
        // Reset held: every output low.
        #12;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_taken", out_taken, 0);
        check("rst.out_target", out_target, 0);
        check("rst.out_is_slt", out_is_slt, 0);
        check("rst.out_slt", out_slt, 0);
        check("rst.out_err", out_err, 0);
        check("rst.flush", flush, 0);
        @(negedge clk);

        // Release with in_valid already high: accepted at the first edge.
        rst_n = 1'b1;
        step(1, 3'd1, 32'd3, 32'd3, 0, 0, 32'h100, 16'd4, 1);
        check("release.out_valid", out_valid, 1);

        // BEQ taken with negative offset; 2-cycle flush window afterwards.
        step(1, 3'd0, 32'd7, 32'd7, 0, 0, 32'h0040_0000, 16'hFFFF, 1);
        check("beq.target", out_target, 32'h0040_0000);
        check("beq.taken", out_taken, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("beq.flush1", flush, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("beq.flush2", flush, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("beq.flush_end", flush, 0);

        // BGTZ not taken, then SLTU back-to-back.
        step(1, 3'd3, 32'hFFFF_FFFB, 0, 0, 0, 32'h200, 16'd8, 1);
        check("bgtz.taken", out_taken, 0);
        step(1, 3'd7, 32'd1, 32'd2, 0, 0, 32'h204, 16'd0, 1);
        check("sltu.is_slt", out_is_slt, 1);
        check("sltu.slt", out_slt, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("sltu.no_flush", flush, 0);

        // BNE taken held under backpressure for 3 cycles, then released.
        step(1, 3'd1, 32'd1, 32'd2, 0, 0, 32'h300, 16'h0010, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("bne.stall_target", out_target, 32'h344);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("bne.flush_start", flush, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // BGEZ with non-one-hot flags {1,1,0}.
        step(1, 3'd5, 32'd5, 0, 1, 3'b110, 32'h400, 16'd2, 1);
        check("bgez_err.err", out_err, 1);
        check("bgez_err.taken", out_taken, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("bgez_err.no_flush", flush, 0);

        // BLTZ taken with wrapping target, then reset during flush cycle 1.
        step(1, 3'd4, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFF8, 16'h0001, 1);
        check("bltz.target_wrap", out_target, 32'h0000_0000);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("bltz.flush1", flush, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.flush", flush, 0);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst.in_ready", in_ready, 1);
        @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom % 4)
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom % 3 == 0) ? ra : $urandom;
            step($urandom % 4 != 0, 3'($urandom % 8), ra, rb, $urandom % 10 == 0,
                 bad_tab[$urandom % 5], $urandom, 16'($urandom), $urandom % 4 != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
